pipe_field_renderer: RTL and testbench

//  Multi-channel pipe renderer for the VGA output path. It draws NUM_PIPES pipe pairs from
//  per-pipe geometry words, with a shaft image and a cap image (the cap is mirrored on the top pipe).

---
 rtl/pipe_field_renderer.sv | 235 +++++++++++++++++++++++
 tb/tb_pipe_field_renderer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_field_renderer.sv
// pipe_field_renderer
//   Draws NUM_PIPES pipe pairs (top + bottom) for the VGA output path. Each channel is described
//   by a left edge, the top row of the bottom pipe and the gap height. The geometry is shadowed
//   once per frame on frame_start. Pixel lookup is a two-stage pipeline: stage 1 resolves the
//   winning channel and image address, stage 2 reads the shaft/cap image and registers outputs.
//   A sticky bird/pipe collision flag is reported at every frame_start.
//
// Ports
//   clk             pixel clock
//   resetn          asynchronous active-low reset
//   frame_start     1-cycle pulse before the first active pixel of a frame
//   pix_valid       x / y / bird_pixel valid this cycle
//   x, y            pixel column / row
//   bird_pixel      bird is opaque at (x,y)
//   pipe_left_flat  per-channel left edge, bits [9:0] of each 32-bit word
//   pipe_bot_flat   per-channel top row of the bottom pipe, bits [8:0]
//   pipe_gap_flat   per-channel gap height, bits [8:0]
//   out_valid       inside_pipe / color_data valid (2 cycles after pix_valid)
//   inside_pipe     pixel is covered by a pipe
//   color_data      pipe colour, 0 outside pipes
//   collision       collision result of the previous frame
//   collision_valid 1-cycle pulse when collision is updated

module pipe_field_renderer #(
  parameter int unsigned NUM_PIPES       = 4,
  parameter int unsigned SCREEN_HEIGHT   = 480,
  parameter int unsigned PIPE_WIDTH      = 70,
  parameter int unsigned PIPE_CAP_HEIGHT = 10,
  parameter int unsigned BITS_PER_COLOR  = 12
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      frame_start,
  input  logic                      pix_valid,
  input  logic [9:0]                x,
  input  logic [8:0]                y,
  input  logic                      bird_pixel,
  input  logic [32*NUM_PIPES-1:0]   pipe_left_flat,
  input  logic [32*NUM_PIPES-1:0]   pipe_bot_flat,
  input  logic [32*NUM_PIPES-1:0]   pipe_gap_flat,
  output logic                      out_valid,
  output logic                      inside_pipe,
  output logic [BITS_PER_COLOR-1:0] color_data,
  output logic                      collision,
  output logic                      collision_valid
);

  // Largest address: (PIPE_WIDTH-1) + PIPE_WIDTH*511 for a 9-bit row.
  localparam int unsigned AddrW     = $clog2(PIPE_WIDTH * 512);
  localparam int unsigned ShaftSize = PIPE_WIDTH * SCREEN_HEIGHT;
  localparam logic [9:0]  CapH      = 10'(PIPE_CAP_HEIGHT);
  localparam logic [10:0] PipeW     = 11'(PIPE_WIDTH);

  // Image ROM contents, generated as a fixed pattern of the address.
  // Shaft rows beyond the image height read as transparent black.
  function automatic logic [BITS_PER_COLOR-1:0] shaft_color(input logic [AddrW-1:0] a);
    logic [AddrW-1:0] m;
    m = a ^ (a >> 8);
    if (32'(a) >= ShaftSize) return '0;
    return m[BITS_PER_COLOR-1:0];
  endfunction

  function automatic logic [BITS_PER_COLOR-1:0] cap_color(input logic [AddrW-1:0] a);
    logic [AddrW-1:0] m;
    m = ~a;
    return m[BITS_PER_COLOR-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Geometry shadow, refreshed only on frame_start
  // ---------------------------------------------------------------------------
  logic [10*NUM_PIPES-1:0] left_q;
  logic [32*NUM_PIPES-1:0] bot_q;
  logic [32*NUM_PIPES-1:0] gap_q;
  logic [NUM_PIPES-1:0]    unused_left_bits;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      left_q <= '0;
      bot_q  <= '0;
      gap_q  <= '0;
    end else if (frame_start) begin
      for (int i = 0; i < int'(NUM_PIPES); i++) begin
        left_q[10*i +: 10] <= pipe_left_flat[32*i +: 10];
      end
      bot_q <= pipe_bot_flat;
      gap_q <= pipe_gap_flat;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel hit detection and row offset within the selected image
  // ---------------------------------------------------------------------------
  logic [NUM_PIPES-1:0] ch_hit;
  logic [NUM_PIPES-1:0] ch_cap;
  logic [9:0]           ch_row [NUM_PIPES];
  logic [9:0]           ch_col [NUM_PIPES];

  for (genvar g = 0; g < int'(NUM_PIPES); g++) begin : gen_ch
    logic [9:0]  l;
    logic [9:0]  b;
    logic [9:0]  gap;
    logic [9:0]  t;
    logic [9:0]  yy;
    logic [10:0] r_edge;
    logic [9:0]  bc_end;
    logic        en;
    logic        in_x;
    logic        top_ok;
    logic        hit_ts;
    logic        hit_tc;
    logic        hit_bc;
    logic        hit_bs;

    assign unused_left_bits[g] = ^pipe_left_flat[32*g+10 +: 22];

    always_comb begin
      l      = left_q[10*g +: 10];
      b      = {1'b0, bot_q[32*g +: 9]};
      gap    = {1'b0, gap_q[32*g +: 9]};
      yy     = {1'b0, y};
      en     = (gap_q[32*g +: 32] != '0) && (bot_q[32*g +: 32] != '0);
      // Right edge computed one bit wider so a pipe near x=1023 does not wrap.
      r_edge = {1'b0, l} + PipeW;
      in_x   = (x >= l) && ({1'b0, x} < r_edge);
      // A gap taller than the bottom pipe's top row leaves no room for a top pipe.
      top_ok = (gap <= b);
      t      = b - gap;
      bc_end = b + CapH;
      // When T < C the top shaft vanishes and the cap is clipped at row 0.
      hit_ts = top_ok && (t >= CapH) && (yy < t - CapH);
      hit_tc = top_ok && (yy < t) && !hit_ts;
      hit_bc = (yy >= b) && (yy < bc_end);
      hit_bs = (yy >= bc_end);

      ch_hit[g] = en && in_x && (hit_ts || hit_tc || hit_bc || hit_bs);
      ch_cap[g] = hit_tc || hit_bc;
      ch_col[g] = x - l;
      if (hit_ts) begin
        ch_row[g] = yy;
      end else if (hit_tc) begin
        ch_row[g] = t - 10'd1 - yy;  // top cap image is mirrored vertically
      end else if (hit_bc) begin
        ch_row[g] = yy - b;
      end else begin
        ch_row[g] = yy - bc_end;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: lowest-index channel wins, single shared address multiply
  // ---------------------------------------------------------------------------
  logic             win_hit;
  logic             win_cap;
  logic [9:0]       win_row;
  logic [9:0]       win_col;
  logic [AddrW-1:0] addr_d;

  always_comb begin
    win_hit = 1'b0;
    win_cap = 1'b0;
    win_row = '0;
    win_col = '0;
    for (int i = int'(NUM_PIPES) - 1; i >= 0; i--) begin
      if (ch_hit[i]) begin
        win_hit = 1'b1;
        win_cap = ch_cap[i];
        win_row = ch_row[i];
        win_col = ch_col[i];
      end
    end
    addr_d = AddrW'(win_col) + AddrW'(win_row) * AddrW'(PIPE_WIDTH);
  end

  logic             v1_q;
  logic             hit1_q;
  logic             cap1_q;
  logic             bird1_q;
  logic [AddrW-1:0] addr1_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      v1_q    <= 1'b0;
      hit1_q  <= 1'b0;
      cap1_q  <= 1'b0;
      bird1_q <= 1'b0;
      addr1_q <= '0;
    end else begin
      v1_q    <= pix_valid;
      hit1_q  <= pix_valid & win_hit;
      cap1_q  <= win_cap;
      bird1_q <= bird_pixel;
      addr1_q <= addr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: image read (registered into the outputs) and collision tracking
  // ---------------------------------------------------------------------------
  logic bird2_q;
  logic sticky_q;
  logic sticky_d;
  logic hit_now;

  always_comb begin
    hit_now = out_valid & inside_pipe & bird2_q;
    // A hit coinciding with frame_start belongs to the frame that is just starting.
    sticky_d = frame_start ? hit_now : (sticky_q | hit_now);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid       <= 1'b0;
      inside_pipe     <= 1'b0;
      color_data      <= '0;
      bird2_q         <= 1'b0;
      sticky_q        <= 1'b0;
      collision       <= 1'b0;
      collision_valid <= 1'b0;
    end else begin
      out_valid       <= v1_q;
      inside_pipe     <= v1_q & hit1_q;
      color_data      <= (v1_q & hit1_q) ?
                         (cap1_q ? cap_color(addr1_q) : shaft_color(addr1_q)) : '0;
      bird2_q         <= v1_q & bird1_q;
      sticky_q        <= sticky_d;
      collision_valid <= frame_start;
      if (frame_start) begin
        collision <= sticky_q;
      end
    end
  end

endmodule

// File: tb/tb_pipe_field_renderer.sv
// Directed bench for pipe_field_renderer with a scoreboard of expected pixel and collision results.
module tb_pipe_field_renderer;

  localparam int unsigned NP = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic          frame_start = 1'b0;
  logic          pix_valid = 1'b0;
  logic [9:0]    x = '0;
  logic [8:0]    y = '0;
  logic          bird_pixel = 1'b0;
  logic [32*NP-1:0] pipe_left_flat = '0;
  logic [32*NP-1:0] pipe_bot_flat = '0;
  logic [32*NP-1:0] pipe_gap_flat = '0;
  logic          out_valid;
  logic          inside_pipe;
  logic [11:0]   color_data;
  logic          collision;
  logic          collision_valid;

  pipe_field_renderer #(
    .NUM_PIPES      (NP),
    .SCREEN_HEIGHT  (480),
    .PIPE_WIDTH     (70),
    .PIPE_CAP_HEIGHT(10),
    .BITS_PER_COLOR (12)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .frame_start    (frame_start),
    .pix_valid      (pix_valid),
    .x              (x),
    .y              (y),
    .bird_pixel     (bird_pixel),
    .pipe_left_flat (pipe_left_flat),
    .pipe_bot_flat  (pipe_bot_flat),
    .pipe_gap_flat  (pipe_gap_flat),
    .out_valid      (out_valid),
    .inside_pipe    (inside_pipe),
    .color_data     (color_data),
    .collision      (collision),
    .collision_valid(collision_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [12:0] val;  // {inside_pipe, color_data}
  } exp_t;

  exp_t exp_q[$];
  logic coll_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Image patterns the design stores in its ROMs.
  function automatic logic [11:0] shaft_c(input int a);
    int m;
    m = a ^ (a >> 8);
    return m[11:0];
  endfunction

  function automatic logic [11:0] cap_c(input int a);
    int m;
    m = ~a;
    return m[11:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    pix_valid  = 1'b0;
    bird_pixel = 1'b0;
    repeat (n) step();
  endtask

  task automatic set_ch(input int ch, input int l, input int b, input int g);
    pipe_left_flat[32*ch +: 32] = 32'(l);
    pipe_bot_flat[32*ch +: 32]  = 32'(b);
    pipe_gap_flat[32*ch +: 32]  = 32'(g);
  endtask

  task automatic frame(input logic exp_coll);
    coll_q.push_back(exp_coll);
    pix_valid   = 1'b0;
    bird_pixel  = 1'b0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  // Drive one pixel; hit/cap/addr are the hand-derived expected lookup.
  task automatic pix(input int px, input int py, input logic bird,
                     input logic hit, input logic cap, input int addr);
    exp_t e;
    e.tag = $sformatf("px(%0d,%0d)", px, py);
    e.val = {hit, hit ? (cap ? cap_c(addr) : shaft_c(addr)) : 12'h000};
    exp_q.push_back(e);
    x          = 10'(px);
    y          = 9'(py);
    bird_pixel = bird;
    pix_valid  = 1'b1;
    step();
  endtask

  // Scoreboard side: pops one expectation for every valid output / collision pulse.
  always @(negedge clk) begin
    exp_t e;
    logic c;
    if (resetn === 1'b1) begin
      if (out_valid === 1'b1) begin
        n_chk++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_out_valid: got out_valid=1 with empty scoreboard, required none");
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          n_chk++;
          assert ({inside_pipe, color_data} === e.val) else begin
            n_fail++;
            $error("FAIL %s: got inside=%0b color=%03h, required inside=%0b color=%03h",
                   e.tag, inside_pipe, color_data, e.val[12], e.val[11:0]);
          end
        end
      end else begin
        n_chk++;
        assert ({inside_pipe, color_data} === 13'd0) else begin
          n_fail++;
          $error("FAIL idle_zero: got inside=%0b color=%03h, required 0/000",
                 inside_pipe, color_data);
        end
      end
      if (collision_valid === 1'b1) begin
        n_chk++;
        assert (coll_q.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_collision_valid: got pulse, required none");
        end
        if (coll_q.size() != 0) begin
          c = coll_q.pop_front();
          n_chk++;
          assert (collision === c) else begin
            n_fail++;
            $error("FAIL collision: got %0b, required %0b", collision, c);
          end
        end
      end
    end
  end

  initial begin
    // Reset
    #1 resetn = 1'b0;
    repeat (3) step();
    n_chk++;
    assert ({out_valid, inside_pipe, color_data, collision, collision_valid} === 16'd0) else begin
      n_fail++;
      $error("FAIL reset_state: got %04h, required 0000",
             {out_valid, inside_pipe, color_data, collision, collision_valid});
    end
    resetn = 1'b1;
    step();

    // 1. All geometry zero: nothing drawn, no collision.
    frame(1'b0);
    pix(120, 320, 1'b1, 1'b0, 1'b0, 0);
    pix(0, 0, 1'b0, 1'b0, 1'b0, 0);
    pix(639, 479, 1'b1, 1'b0, 1'b0, 0);
    idle(3);
    frame(1'b0);

    // 2. Single pipe: L=100 B=300 G=100 -> T=200.
    set_ch(0, 100, 300, 100);
    frame(1'b0);
    pix(120, 195, 1'b0, 1'b1, 1'b1, 300);
    pix(120, 250, 1'b0, 1'b0, 1'b0, 0);
    pix(120, 305, 1'b0, 1'b1, 1'b1, 370);
    pix(120, 320, 1'b0, 1'b1, 1'b0, 720);
    pix(170, 320, 1'b0, 1'b0, 1'b0, 0);
    pix(169, 320, 1'b0, 1'b1, 1'b0, 769);
    pix(100, 320, 1'b0, 1'b1, 1'b0, 700);
    pix(99, 320, 1'b0, 1'b0, 1'b0, 0);
    pix(120, 100, 1'b0, 1'b1, 1'b0, 7020);
    pix(120, 189, 1'b0, 1'b1, 1'b0, 13250);
    pix(120, 190, 1'b0, 1'b1, 1'b1, 650);
    pix(120, 199, 1'b0, 1'b1, 1'b1, 20);
    pix(120, 200, 1'b0, 1'b0, 1'b0, 0);
    pix(120, 299, 1'b0, 1'b0, 1'b0, 0);
    pix(120, 309, 1'b0, 1'b1, 1'b1, 650);
    pix(120, 310, 1'b0, 1'b1, 1'b0, 20);
    pix(170, 250, 1'b0, 1'b0, 1'b0, 0);
    idle(3);

    // 3. Overlap: ch0 wins; with ch0 disabled ch1 shows.
    set_ch(1, 130, 300, 100);
    frame(1'b0);
    pix(140, 320, 1'b0, 1'b1, 1'b0, 740);
    idle(3);
    set_ch(0, 100, 300, 0);
    frame(1'b0);
    pix(140, 320, 1'b0, 1'b1, 1'b0, 710);
    idle(3);

    // 4. Mid-frame left-edge change is deferred to the next frame.
    set_ch(1, 130, 300, 0);
    set_ch(0, 100, 300, 100);
    frame(1'b0);
    pix(120, 320, 1'b0, 1'b1, 1'b0, 720);
    pipe_left_flat[31:0] = 32'd200;
    pix(120, 320, 1'b0, 1'b1, 1'b0, 720);
    pix(220, 320, 1'b0, 1'b0, 1'b0, 0);
    idle(3);
    frame(1'b0);
    pix(120, 320, 1'b0, 1'b0, 1'b0, 0);
    pix(220, 320, 1'b0, 1'b1, 1'b0, 720);
    idle(3);

    // 5. Collision on channel 2.
    set_ch(0, 0, 0, 0);
    set_ch(2, 100, 300, 100);
    frame(1'b0);
    pix(120, 320, 1'b1, 1'b1, 1'b0, 720);
    pix(50, 320, 1'b1, 1'b0, 1'b0, 0);
    idle(3);
    frame(1'b1);
    pix(120, 320, 1'b0, 1'b1, 1'b0, 720);
    idle(3);
    frame(1'b0);
    // Hit lands on the same cycle as the next frame_start.
    pix(120, 320, 1'b1, 1'b1, 1'b0, 720);
    idle(1);
    frame(1'b0);
    idle(2);
    frame(1'b1);

    // 6. G > B: no top pipe.
    set_ch(2, 0, 0, 0);
    set_ch(0, 100, 200, 250);
    frame(1'b0);
    pix(120, 50, 1'b0, 1'b0, 1'b0, 0);
    pix(120, 205, 1'b1, 1'b1, 1'b1, 370);
    idle(3);
    // T=5 < C: cap clipped to rows 0..4.
    set_ch(0, 100, 100, 95);
    frame(1'b1);
    pix(120, 0, 1'b0, 1'b1, 1'b1, 300);
    pix(120, 4, 1'b0, 1'b1, 1'b1, 20);
    pix(120, 5, 1'b0, 1'b0, 1'b0, 0);
    pix(120, 100, 1'b0, 1'b1, 1'b1, 20);
    pix(120, 0, 1'b0, 1'b1, 1'b1, 300);
    // Outputs currently show px(120,100); reset asynchronously mid-cycle.
    #2 resetn = 1'b0;
    #1;
    n_chk++;
    assert ({out_valid, inside_pipe, color_data, collision, collision_valid} === 16'd0) else begin
      n_fail++;
      $error("FAIL async_reset: got %04h, required 0000",
             {out_valid, inside_pipe, color_data, collision, collision_valid});
    end
    exp_q.delete();
    pix_valid = 1'b0;
    repeat (2) step();
    #2 resetn = 1'b1;
    idle(4);

    n_chk++;
    assert (exp_q.size() == 0 && coll_q.size() == 0) else begin
      n_fail++;
      $error("FAIL drain: got %0d pixels and %0d collisions outstanding, required 0 and 0",
             exp_q.size(), coll_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
